// File: rtl/dwt_pair_packer.sv
// Packs a one-sample-per-beat line stream into {odd, even} pairs for the DWT 9/7 row path.
// Odd-length lines are closed with whole-sample symmetric extension (x[N] = x[N-2]).
module dwt_pair_packer #(
   parameter int DataWidth       = 16,
   parameter int MaximumSideSize = 512
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   s_ready_o,
   input  logic                   s_valid_i,
   input  logic                   s_sof_i,
   input  logic                   s_eol_i,
   input  logic [DataWidth-1:0]   s_data_i,
   input  logic                   m_ready_i,
   output logic                   m_valid_o,
   output logic                   m_sof_o,
   output logic                   m_eol_o,
   output logic [2*DataWidth-1:0] m_data_o,
   output logic                   err_o
);
   localparam int MaxPairs = MaximumSideSize / 2;
   localparam int CntW     = $clog2(MaxPairs + 1);

   typedef enum logic {EVEN, ODD} state_t;

   state_t                 state, state_nxt;
   logic [DataWidth-1:0]   held_even, held_even_nxt;
   logic [DataWidth-1:0]   last_odd, last_odd_nxt;
   logic                   hold_sof, hold_sof_nxt;
   logic [CntW-1:0]        cnt, cnt_nxt;
   logic                   err_nxt, valid_nxt;
   logic                   acc, emit, emit_sof, emit_eol;
   logic [2*DataWidth-1:0] emit_data;

   assign s_ready_o = !m_valid_o | m_ready_i;
   assign acc       = s_valid_i & s_ready_o;

   always_comb begin
      state_nxt     = state;
      held_even_nxt = held_even;
      last_odd_nxt  = last_odd;
      hold_sof_nxt  = hold_sof;
      cnt_nxt       = cnt;
      err_nxt       = err_o;
      emit          = 1'b0;
      emit_sof      = 1'b0;
      emit_eol      = 1'b0;
      emit_data     = '0;
      if (acc) begin
         // sof mid-pair abandons the held even; the sample restarts the frame as x[0]
         if (state == ODD && s_sof_i) err_nxt = 1'b1;
         if (state == EVEN || s_sof_i) begin
            if (!s_eol_i) begin
               held_even_nxt = s_data_i;
               hold_sof_nxt  = s_sof_i;
               state_nxt     = ODD;
               if (s_sof_i) cnt_nxt = '0;
            end else begin
               // line ends on an even position: mirror x[N-2]; a 1-sample line mirrors itself
               emit      = 1'b1;
               emit_sof  = s_sof_i;
               emit_eol  = 1'b1;
               emit_data = {((cnt == '0) || s_sof_i) ? s_data_i : last_odd, s_data_i};
               cnt_nxt   = '0;
               state_nxt = EVEN;
            end
         end else begin
            emit         = 1'b1;
            emit_sof     = hold_sof;
            emit_eol     = s_eol_i;
            emit_data    = {s_data_i, held_even};
            last_odd_nxt = s_data_i;
            state_nxt    = EVEN;
            if (s_eol_i) begin
               cnt_nxt = '0;
            end else if (cnt != CntW'(MaxPairs)) begin
               cnt_nxt = cnt + CntW'(1);
               if (cnt == CntW'(MaxPairs - 1)) err_nxt = 1'b1;
            end
         end
      end
      valid_nxt = emit ? 1'b1 : (m_ready_i ? 1'b0 : m_valid_o);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state     <= EVEN;
         held_even <= '0;
         last_odd  <= '0;
         hold_sof  <= 1'b0;
         cnt       <= '0;
         err_o     <= 1'b0;
         m_valid_o <= 1'b0;
         m_sof_o   <= 1'b0;
         m_eol_o   <= 1'b0;
         m_data_o  <= '0;
      end else begin
         state     <= state_nxt;
         held_even <= held_even_nxt;
         last_odd  <= last_odd_nxt;
         hold_sof  <= hold_sof_nxt;
         cnt       <= cnt_nxt;
         err_o     <= err_nxt;
         m_valid_o <= valid_nxt;
         if (emit) begin
            m_sof_o  <= emit_sof;
            m_eol_o  <= emit_eol;
            m_data_o <= emit_data;
         end
      end
   end
endmodule

// File: tb/tb_dwt_pair_packer.sv
// Scoreboard bench for dwt_pair_packer: expected pairs are queued as lines are driven
// and popped when the packer hands a pair downstream.
module tb_dwt_pair_packer;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          s_ready_o, s_valid_i, s_sof_i, s_eol_i;
   logic [DW-1:0] s_data_i;
   logic          m_ready_i, m_valid_o, m_sof_o, m_eol_o, err_o;
   logic [2*DW-1:0] m_data_o;

   int n_vec = 0, n_miss = 0;
   logic [2*DW+1:0] sb_q[$];
   logic            stall_prev = 1'b0;
   logic [2*DW+2:0] prev_out;

   dwt_pair_packer #(.DataWidth(DW), .MaximumSideSize(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .s_ready_o(s_ready_o), .s_valid_i(s_valid_i),
      .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_data_i(s_data_i), .m_ready_i(m_ready_i),
      .m_valid_o(m_valid_o), .m_sof_o(m_sof_o), .m_eol_o(m_eol_o), .m_data_o(m_data_o),
      .err_o(err_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void exp_pair(input int odd, input int even, input bit sof, input bit eol);
      sb_q.push_back({sof, eol, DW'(odd), DW'(even)});
   endfunction

   // drive one sample; returns at posedge+1 after it is accepted
   task automatic send(input int x, input bit sof, input bit eol);
      int t = 0;
      s_valid_i = 1'b1; s_sof_i = sof; s_eol_i = eol; s_data_i = DW'(x);
      forever begin
         @(negedge clk);
         if (s_ready_o) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         if (++t > 100) begin
            chk("s_ready_timeout", 64'd0, 64'd1);
            break;
         end
      end
      s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b0; s_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(m_valid_o), 64'd0);
      chk("rst_flags", {62'd0, m_sof_o, m_eol_o}, 64'd0);
      chk("rst_data",  64'(m_data_o), 64'd0);
      chk("rst_err",   64'(err_o), 64'd0);
      rst_i = 1'b1;
   endtask

   // scoreboard side: compare on handshake, and check hold-stability while stalled
   always @(negedge clk) begin
      if (rst_i) begin
         if (stall_prev)
            chk("stall_hold", 64'({m_valid_o, m_sof_o, m_eol_o, m_data_o}), 64'(prev_out));
         if (m_valid_o && m_ready_i) begin
            if (sb_q.size() == 0) chk("unexpected_pair", 64'({m_sof_o, m_eol_o, m_data_o}), 64'd0);
            else chk("pair", 64'({m_sof_o, m_eol_o, m_data_o}), 64'(sb_q.pop_front()));
         end
         stall_prev = m_valid_o && !m_ready_i;
         prev_out   = {m_valid_o, m_sof_o, m_eol_o, m_data_o};
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0; s_data_i = '0; m_ready_i = 1'b1;
      do_reset();

      // even line 0..7: exactly MaximumSideSize samples, so no error
      exp_pair(1, 0, 1, 0); exp_pair(3, 2, 0, 0); exp_pair(5, 4, 0, 0); exp_pair(7, 6, 0, 1);
      for (int i = 0; i < 8; i++) send(i, i == 0, i == 7);
      drain();
      chk("err_full_line", 64'(err_o), 64'd0);

      // odd line: last pair mirrors x[3]
      exp_pair(11, 10, 1, 0); exp_pair(13, 12, 0, 0); exp_pair(13, 14, 0, 1);
      for (int i = 0; i < 5; i++) send(10 + i, i == 0, i == 4);
      drain();

      // single-sample line
      exp_pair(5, 5, 1, 1);
      send(5, 1, 1);
      drain();

      // downstream stall for 5 clk after the first pair
      exp_pair(21, 20, 1, 0); exp_pair(23, 22, 0, 0); exp_pair(25, 24, 0, 1);
      m_ready_i = 1'b0;
      send(20, 1, 0);
      send(21, 0, 0);
      @(negedge clk);
      chk("stall_s_ready", 64'(s_ready_o), 64'd0);
      chk("stall_m_valid", 64'(m_valid_o), 64'd1);
      @(posedge clk); #1;
      fork
         for (int i = 22; i < 26; i++) send(i, 1'b0, i == 25);
         begin repeat (4) @(posedge clk); #1; m_ready_i = 1'b1; end
      join
      drain();
      chk("err_before_sof", 64'(err_o), 64'd0);

      // sof on the odd position: 40 is dropped, frame restarts at 41
      exp_pair(42, 41, 1, 0); exp_pair(44, 43, 0, 1);
      send(40, 1, 0);
      send(41, 1, 0);
      chk("err_sof_odd", 64'(err_o), 64'd1);
      send(42, 0, 0); send(43, 0, 0); send(44, 0, 1);
      drain();

      // 10-sample line with MaximumSideSize=8: error on the 4th pair, all pairs still out
      do_reset();
      for (int k = 0; k < 5; k++) exp_pair(51 + 2 * k, 50 + 2 * k, k == 0, k == 4);
      for (int i = 0; i < 10; i++) begin
         send(50 + i, i == 0, i == 9);
         if (i == 5) chk("err_3rd_pair", 64'(err_o), 64'd0);
         if (i == 7) chk("err_4th_pair", 64'(err_o), 64'd1);
      end
      drain();
      chk("err_sticky", 64'(err_o), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
